// File: rtl/log2_sched.sv
// Round-robin scheduler sharing one iterative floor(log2) unit among NREQ requesters.
// Optional macro LOG2_ZERO_ERR_EN adds o_out_err, flagging a zero operand alongside each result.
module log2_sched #(
    parameter int NREQ    = 4,
    parameter int BIT_IN  = 12,
    parameter int BIT_OUT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*BIT_IN-1:0]   i_dat_in,
    output logic [NREQ-1:0]          o_gnt,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [BIT_OUT-1:0]       o_dat_out,
    output logic [$clog2(NREQ)-1:0]  o_out_id,
    output logic                     o_busy
`ifdef LOG2_ZERO_ERR_EN
    ,
    output logic                     o_out_err
`endif
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_HOLD
    } state_t;

    state_t               r_state;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_idx;
    logic [IDW-1:0]       r_id;
    logic [BIT_IN-1:0]    r_opd;
    logic [BIT_OUT-1:0]   r_cnt;
    logic [BIT_OUT-1:0]   r_dat;
    logic                 r_valid;
`ifdef LOG2_ZERO_ERR_EN
    logic                 r_err;
`endif

    logic [BIT_IN-1:0]    w_opd [NREQ];
    logic                 w_any;
    logic [IDW-1:0]       w_win;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_opd
            assign w_opd[gi] = i_dat_in[gi*BIT_IN +: BIT_IN];
        end
    endgenerate

    // Scan from the highest offset down so the requester closest to r_ptr wins.
    always_comb begin
        w_any = |i_req;
        w_win = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[r_ptr + IDW'(k)]) begin
                w_win = r_ptr + IDW'(k);
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        if (r_state == S_IDLE && w_any) begin
            o_gnt[w_win] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_id    <= '0;
            r_opd   <= '0;
            r_cnt   <= '0;
            r_dat   <= '0;
            r_valid <= 1'b0;
`ifdef LOG2_ZERO_ERR_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_opd   <= w_opd[w_win];
                        r_idx   <= w_win;
                        r_cnt   <= '0;
                        r_ptr   <= w_win + IDW'(1);
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_opd <= BIT_IN'(1)) begin
                        r_dat   <= r_cnt;
                        r_id    <= r_idx;
                        r_valid <= 1'b1;
`ifdef LOG2_ZERO_ERR_EN
                        // Shifting never reaches zero from >=2, so zero here means a zero operand.
                        r_err   <= (r_opd == '0);
`endif
                        r_state <= S_HOLD;
                    end else begin
                        r_opd <= r_opd >> 1;
                        r_cnt <= r_cnt + BIT_OUT'(1);
                    end
                end
                S_HOLD: begin
                    if (i_out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_out_valid = r_valid;
    assign o_dat_out   = r_dat;
    assign o_out_id    = r_id;
    assign o_busy      = (r_state != S_IDLE);
`ifdef LOG2_ZERO_ERR_EN
    assign o_out_err   = r_err;
`endif

endmodule

// File: tb/tb_log2_sched.sv
// Scoreboard bench for log2_sched: stimulus pushes expected grants/results, a negedge monitor checks them.
module tb_log2_sched;

    localparam int NREQ    = 4;
    localparam int BIT_IN  = 12;
    localparam int BIT_OUT = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*BIT_IN-1:0]  dat_in = '0;
    logic [NREQ-1:0]         gnt;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [BIT_OUT-1:0]      dat_out;
    logic [1:0]              out_id;
    logic                    busy;
`ifdef LOG2_ZERO_ERR_EN
    logic                    out_err;
`endif

    log2_sched #(.NREQ(NREQ), .BIT_IN(BIT_IN), .BIT_OUT(BIT_OUT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_dat_in    (dat_in),
        .o_gnt       (gnt),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_dat_out   (dat_out),
        .o_out_id    (out_id),
        .o_busy      (busy)
`ifdef LOG2_ZERO_ERR_EN
        ,
        .o_out_err   (out_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int dat;
        int err;
        int lat;
    } res_t;

    res_t exp_q[$];
    int   gnt_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_gnt_cyc = -100;
    int   space_chk = 0;
    int   space_armed = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
        end
    endtask

    // Monitor: grants and results are matched against the queues in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (gnt != '0) begin
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 0);
                end else begin
                    int g;
                    g = gnt_q.pop_front();
                    chk("gnt", 32'(gnt), 32'(1 << g));
                    $display("grant id=%0d cyc=%0d", g, cyc);
                end
                if (space_chk != 0 && space_armed != 0) chk("gnt_spacing", cyc - last_gnt_cyc, 3);
                space_armed = space_chk;
                last_gnt_cyc = cyc;
            end
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("result_unexpected", 1, 0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("out_id", 32'(out_id), e.id);
                    chk("dat_out", 32'(dat_out), e.dat);
                    chk("latency", cyc - last_gnt_cyc, e.lat);
`ifdef LOG2_ZERO_ERR_EN
                    chk("out_err", 32'(out_err), e.err);
`endif
                    $display("result id=%0d dat=%0d lat=%0d", out_id, dat_out, cyc - last_gnt_cyc);
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic push_res(input int idx, input int val, input int exp_dat);
        res_t r;
        r.id  = idx;
        r.dat = exp_dat;
        r.err = (val == 0) ? 1 : 0;
        r.lat = exp_dat + 2;
        exp_q.push_back(r);
    endtask

    task automatic wait_gnt_drop(input int idx);
        int n;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (gnt[idx]) break;
        end
        if (n == 60) chk("gnt_timeout", 1, 0);
        @(posedge clk);
        #1 req[idx] = 1'b0;
    endtask

    task automatic issue(input int idx, input int val, input int exp_dat, input bit with_res);
        @(posedge clk);
        #1;
        dat_in[idx*BIT_IN +: BIT_IN] = BIT_IN'(val);
        req[idx] = 1'b1;
        gnt_q.push_back(idx);
        if (with_res) push_res(idx, val, exp_dat);
        wait_gnt_drop(idx);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        if (n == 100) chk("idle_timeout", 1, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_dat"}, 32'(dat_out), 0);
        chk({tag, "_id"}, 32'(out_id), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");

        // Request present at release: grant on the first rising edge.
        req[0] = 1'b1;
        dat_in[0 +: BIT_IN] = 12'd1;
        gnt_q.push_back(0);
        push_res(0, 1, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_gnt_drop(0);
        chk("busy_calc", 32'(busy), 1);
        wait_idle();

        issue(2, 4095, 11, 1'b1);
        wait_idle();
        issue(2, 1024, 10, 1'b1);
        wait_idle();
        issue(1, 0, 0, 1'b1);
        wait_idle();
        issue(3, 2, 1, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("dat_hold_idle", 32'(dat_out), 1);
        chk("valid_low_idle", 32'(out_valid), 0);

        // Backpressure: result must sit unchanged while a new request waits.
        out_ready = 1'b0;
        issue(1, 5, 2, 1'b1);
        begin
            int n;
            for (n = 0; n < 40; n++) begin
                @(negedge clk);
                if (out_valid) break;
            end
            if (n == 40) chk("valid_timeout", 1, 0);
        end
        dat_in[3*BIT_IN +: BIT_IN] = 12'd1;
        req[3] = 1'b1;
        gnt_q.push_back(3);
        push_res(3, 1, 0);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_dat", 32'(dat_out), 2);
            chk("hold_id", 32'(out_id), 1);
            chk("hold_gnt", 32'(gnt), 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_gnt_drop(3);
        wait_idle();

        // Abort a long operation with reset mid-CALC.
        issue(0, 4095, 11, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_valid", 32'(out_valid), 0);
        chk("abort_idle", 32'(busy), 0);

        // All requesters held: order restarts from 0, grants 3 cycles apart.
        space_chk = 1;
        @(posedge clk);
        #1;
        dat_in = {12'd0, 12'd1, 12'd0, 12'd1};
        gnt_q.push_back(0); push_res(0, 1, 0);
        gnt_q.push_back(1); push_res(1, 0, 0);
        gnt_q.push_back(2); push_res(2, 1, 0);
        gnt_q.push_back(3); push_res(3, 0, 0);
        gnt_q.push_back(0); push_res(0, 1, 0);
        req = 4'b1111;
        begin
            int n;
            for (n = 0; n < 40; n++) begin
                @(posedge clk);
                if (gnt_q.size() == 0) break;
            end
            if (n == 40) chk("rr_timeout", 1, 0);
        end
        #1 req = '0;
        wait_idle();
        space_chk = 0;

        chk("queue_empty", exp_q.size(), 0);
        chk("gnt_queue_empty", gnt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
